alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 s  input  1  start: execute the instruction held in IR.
REQ-005 load  input  1  capture in into IR.
REQ-006 in  input  16  instruction word.
REQ-007 w  output  1  high only in WAIT (ready for s).
REQ-008 readnum, writenum  output  3 each  register-file read/write index.
REQ-009 write, loada, loadb, loadc, loads, asel, bsel  output  1 each  datapath strobes and selects.
REQ-010 vsel  output  2  writeback source: 00 = C, 10 = sximm8, others unused.
REQ-011 ALUop, shift  output  2 each  ALU operation and shifter control.
REQ-012 sximm8  output  16  IR[7:0] sign-extended, combinational from IR.

Function
REQ-013 IR fields SHALL be: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0].
REQ-014 Decoded instructions SHALL be:
- MOVI: opcode 110, op 10.
- MOVR: opcode 110, op 00.
- ALU: opcode 101, op = ALUop (00 ADD, 01 CMP, 10 AND, 11 MVN).
- All other encodings are undefined.
REQ-015 The FSM SHALL have the states WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM.
REQ-016 IR SHALL load in on a clk edge only when load=1 and the state is WAIT; load is ignored in all other states.
REQ-017 WAIT: w=1; with s=1 the FSM SHALL go to DECODE; with s=0 it stays in WAIT.
REQ-018 If load and s are both 1 in WAIT, IR SHALL capture the new word and DECODE SHALL act on that new word.
REQ-019 DECODE SHALL go to: WRITE_IMM for MOVI; GET_B for MOVR and MVN; GET_A for ADD, CMP and AND; WAIT for an undefined encoding, with no write.
REQ-020 GET_A: readnum=Rn, loada=1; next state GET_B.
REQ-021 GET_B: readnum=Rm, loadb=1; next state EXEC.
REQ-022 EXEC SHALL drive:
- shift=sh, bsel=0;
- ALUop=op for ALU instructions, ALUop=00 with asel=1 (A forced to 0) for MOVR, asel=0 otherwise.
REQ-023 EXEC strobes: loadc=1 and next state WRITE_REG, except for CMP, which drives loads=1, loadc=0 and next state WAIT.
REQ-024 WRITE_REG: writenum=Rd, vsel=00, write=1; next state WAIT.
REQ-025 WRITE_IMM: writenum=Rn, vsel=10, write=1; next state WAIT.
REQ-026 Every output not named for a state SHALL be 0 in that state; outputs SHALL be Moore outputs decoded from the state and IR.
REQ-027 Latency, counted in cycles after the edge that samples s=1, until w returns high:
- MOVI: 3.
- MOVR, MVN: 5.
- CMP: 5.
- ADD, AND: 6.
REQ-028 s asserted outside WAIT SHALL be ignored; there is no queuing.
REQ-029 write SHALL be high for exactly one cycle per writing instruction; loads is high only in CMP EXEC.

Reset
REQ-030 While reset=1: state=WAIT, IR=0, w=1, and all other outputs 0 except sximm8=0.
REQ-031 Reset asserted mid-instruction SHALL abort it at once; no write strobe is issued after reset asserts.
REQ-032 After reset deasserts, the first clk edge SHALL evaluate WAIT normally.

Verification
REQ-033 Bench SHALL load 16'hD2FF (MOVI R2,#-1) and pulse s -> WRITE_IMM has writenum=2, vsel=10, sximm8=16'hFFFF, write=1; w is high 3 cycles after s.
REQ-034 Bench SHALL run ADD R3,R1,R2 LSL#1 (16'hA16A) -> sequence GET_A (readnum=1), GET_B (readnum=2), EXEC (ALUop=00, shift=01, loadc=1), WRITE_REG (writenum=3, write=1).
REQ-035 Bench SHALL run CMP R1,R2 (16'hA902) -> EXEC has loads=1, loadc=0; write is never asserted; FSM returns to WAIT.
REQ-036 Bench SHALL run MVN R4,R5 and MOVR R6,R7 -> GET_A is skipped; for MOVR, EXEC has asel=1 and ALUop=00.
REQ-037 Bench SHALL pulse load mid-instruction, then assert reset in GET_B -> IR is unchanged by the load, the state is WAIT immediately, write stays 0, and w=1.
REQ-038 Bench SHALL load an undefined encoding (16'h0000) and pulse s -> DECODE, then WAIT, with no strobes asserted.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for a simple register-file/ALU datapath.
// Decodes the instruction held in IR and sequences the datapath strobes for MOV and ALU ops.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_EXEC      = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_WRITE_IMM = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        I_MOVI  = 3'd0,
        I_MOVR  = 3'd1,
        I_ADD   = 3'd2,
        I_CMP   = 3'd3,
        I_AND   = 3'd4,
        I_MVN   = 3'd5,
        I_UNDEF = 3'd6
    } instr_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] aluop;
        logic [1:0] shift;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE  = ctrl_t'(20'd0);
    localparam ctrl_t CTRL_RESET = ctrl_t'({1'b1, 19'd0});

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] ir_r;
    logic [15:0] next_ir_s;
    ctrl_t       ctrl_r;

    function automatic instr_t classify(input logic [15:0] ir);
        instr_t k;
        case ({ir[15:13], ir[12:11]})
            5'b110_10: k = I_MOVI;
            5'b110_00: k = I_MOVR;
            5'b101_00: k = I_ADD;
            5'b101_01: k = I_CMP;
            5'b101_10: k = I_AND;
            5'b101_11: k = I_MVN;
            default:   k = I_UNDEF;
        endcase
        return k;
    endfunction

    // Control word that belongs to a given state and instruction word.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] ir);
        ctrl_t  c;
        instr_t k;
        c = CTRL_IDLE;
        k = classify(ir);
        case (st)
            ST_WAIT: c.w = 1'b1;
            ST_DECODE: c = CTRL_IDLE;
            ST_GET_A: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            ST_GET_B: begin
                c.readnum = ir[2:0];
                c.loadb   = 1'b1;
            end
            ST_EXEC: begin
                c.shift = ir[4:3];
                c.bsel  = 1'b0;
                // MOVR passes B through by forcing A to zero and adding.
                if (k == I_MOVR) begin
                    c.asel  = 1'b1;
                    c.aluop = 2'b00;
                end else begin
                    c.asel  = 1'b0;
                    c.aluop = ir[12:11];
                end
                if (k == I_CMP) begin
                    c.loads = 1'b1;
                end else begin
                    c.loadc = 1'b1;
                end
            end
            ST_WRITE_REG: begin
                c.writenum = ir[7:5];
                c.vsel     = 2'b00;
                c.write    = 1'b1;
            end
            ST_WRITE_IMM: begin
                c.writenum = ir[10:8];
                c.vsel     = 2'b10;
                c.write    = 1'b1;
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    // IR only accepts a new word while the sequencer is idle.
    always_comb begin
        next_ir_s = ir_r;
        if ((state_r == ST_WAIT) && load) begin
            next_ir_s = in;
        end else begin
            next_ir_s = ir_r;
        end
    end

    // Next-state decode; DECODE sees the word captured on the same edge as s.
    always_comb begin
        next_state_s = ST_WAIT;
        case (state_r)
            ST_WAIT: begin
                if (s) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DECODE: begin
                case (classify(ir_r))
                    I_MOVI:                next_state_s = ST_WRITE_IMM;
                    I_MOVR, I_MVN:         next_state_s = ST_GET_B;
                    I_ADD, I_CMP, I_AND:   next_state_s = ST_GET_A;
                    default:               next_state_s = ST_WAIT;
                endcase
            end
            ST_GET_A: next_state_s = ST_GET_B;
            ST_GET_B: next_state_s = ST_EXEC;
            ST_EXEC: begin
                if (classify(ir_r) == I_CMP) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: next_state_s = ST_WAIT;
            ST_WRITE_IMM: next_state_s = ST_WAIT;
            default:      next_state_s = ST_WAIT;
        endcase
    end

    // State, IR and control word; the control word is precomputed from the next state
    // so the outputs are flops yet line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_WAIT;
            ir_r    <= 16'd0;
            ctrl_r  <= CTRL_RESET;
        end else begin
            state_r <= next_state_s;
            ir_r    <= next_ir_s;
            ctrl_r  <= decode_ctrl(next_state_s, next_ir_s);
        end
    end

    assign w        = ctrl_r.w;
    assign readnum  = ctrl_r.readnum;
    assign writenum = ctrl_r.writenum;
    assign write    = ctrl_r.write;
    assign loada    = ctrl_r.loada;
    assign loadb    = ctrl_r.loadb;
    assign loadc    = ctrl_r.loadc;
    assign loads    = ctrl_r.loads;
    assign asel     = ctrl_r.asel;
    assign bsel     = ctrl_r.bsel;
    assign vsel     = ctrl_r.vsel;
    assign ALUop    = ctrl_r.aluop;
    assign shift    = ctrl_r.shift;
    assign sximm8   = {{8{ir_r[7]}}, ir_r[7:0]};

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table, reset/load corner sequences,
// and randomized instructions compared cycle by cycle against an instruction-level model.
module tb_alu_sequencer;

    logic        clk;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, ALUop, shift;
    logic [15:0] sximm8;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(w), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .ALUop(ALUop), .shift(shift),
        .sximm8(sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write, loada, loadb, loadc, loads, asel, bsel;
        logic [1:0]  vsel, aluop, shift;
        logic [15:0] sximm8;
    } obs_t;

    typedef struct {
        logic [15:0] word;
        int          lat;
        int          nwr;
        logic [2:0]  wnum;
    } vec_t;

    int   vectors;
    int   miscompares;
    obs_t exp_q[$];

    function automatic obs_t sample_dut();
        obs_t o;
        o.w = w; o.readnum = readnum; o.writenum = writenum;
        o.write = write; o.loada = loada; o.loadb = loadb; o.loadc = loadc;
        o.loads = loads; o.asel = asel; o.bsel = bsel;
        o.vsel = vsel; o.aluop = ALUop; o.shift = shift; o.sximm8 = sximm8;
        return o;
    endfunction

    function automatic obs_t blank(input logic [15:0] word);
        obs_t o;
        o = '0;
        o.sximm8 = {{8{word[7]}}, word[7:0]};
        return o;
    endfunction

    // Instruction-level model: list of control words seen after the s edge, ending in WAIT.
    task automatic build_expect(input logic [15:0] word);
        obs_t o;
        bit   is_alu, movi, movr, is_cmp;
        logic [1:0] op;
        op     = word[12:11];
        is_alu = (word[15:13] == 3'b101);
        movi   = (word[15:13] == 3'b110) && (op == 2'b10);
        movr   = (word[15:13] == 3'b110) && (op == 2'b00);
        is_cmp = is_alu && (op == 2'b01);
        exp_q.delete();
        exp_q.push_back(blank(word));
        if (is_alu && op != 2'b11) begin
            o = blank(word); o.readnum = word[10:8]; o.loada = 1'b1;
            exp_q.push_back(o);
        end
        if (is_alu || movr) begin
            o = blank(word); o.readnum = word[2:0]; o.loadb = 1'b1;
            exp_q.push_back(o);
            o = blank(word); o.shift = word[4:3]; o.asel = movr;
            o.aluop = is_alu ? op : 2'b00;
            o.loadc = !is_cmp; o.loads = is_cmp;
            exp_q.push_back(o);
            if (!is_cmp) begin
                o = blank(word); o.writenum = word[7:5]; o.write = 1'b1;
                exp_q.push_back(o);
            end
        end
        if (movi) begin
            o = blank(word); o.writenum = word[10:8]; o.vsel = 2'b10; o.write = 1'b1;
            exp_q.push_back(o);
        end
        o = blank(word); o.w = 1'b1;
        exp_q.push_back(o);
    endtask

    task automatic check_obs(input string name, input obs_t got, input obs_t expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    task automatic check_int(input string name, input int got, input int expv);
        vectors++;
        if (got != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Starts an instruction from WAIT (load and s together) and follows it back to WAIT.
    task automatic run_instr(input logic [15:0] word, input bit noise,
                             output int lat, output int nwr, output logic [2:0] wnum);
        obs_t got;
        bit   done;
        build_expect(word);
        lat = 0; nwr = 0; wnum = 3'd0; done = 1'b0;
        @(negedge clk);
        in = word; load = 1'b1; s = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            got = sample_dut();
            lat = c + 1;
            if (c < exp_q.size()) check_obs($sformatf("step%0d_%h", c, word), got, exp_q[c]);
            if (got.write) begin
                nwr++;
                wnum = got.writenum;
            end
            if (got.w) begin
                done = 1'b1;
                break;
            end
            s    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            load = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            in   = 16'($urandom);
        end
        s = 1'b0; load = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL timeout_%h: w stayed 0, expected 1 within 12 cycles", word);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] wd;
        logic [2:0]  opc;
        int          k;
        wd = 16'($urandom);
        k  = $urandom_range(0, 7);
        case (k)
            0: wd[15:11] = 5'b110_10;
            1: wd[15:11] = 5'b110_00;
            2, 3, 4, 5: wd[15:11] = {3'b101, 2'(k - 2)};
            6: wd[15:11] = {3'b110, 1'($urandom_range(0, 1)), 1'b1};
            default: begin
                opc = 3'($urandom_range(0, 7));
                if (opc == 3'b101 || opc == 3'b110) opc = 3'b000;
                wd[15:13] = opc;
            end
        endcase
        return wd;
    endfunction

    vec_t tbl[7];

    initial begin
        obs_t       rst_obs, o;
        int         lat, nwr;
        logic [2:0] wnum;
        logic [15:0] wd;

        vectors = 0; miscompares = 0;
        tbl[0] = '{16'hD2FF, 3, 1, 3'd2};  // MOVI R2,#-1
        tbl[1] = '{16'hA16A, 6, 1, 3'd3};  // ADD R3,R1,R2 LSL#1
        tbl[2] = '{16'hA902, 5, 0, 3'd0};  // CMP R1,R2
        tbl[3] = '{16'hB885, 5, 1, 3'd4};  // MVN R4,R5
        tbl[4] = '{16'hC0C7, 5, 1, 3'd6};  // MOVR R6,R7
        tbl[5] = '{16'hB143, 6, 1, 3'd2};  // AND R2,R1,R3
        tbl[6] = '{16'h0000, 2, 0, 3'd0};  // undefined

        rst_obs = '0; rst_obs.w = 1'b1;
        reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'd0;
        repeat (2) @(negedge clk);
        check_obs("reset_state", sample_dut(), rst_obs);
        reset = 1'b0;
        @(negedge clk);
        check_obs("idle_after_reset", sample_dut(), rst_obs);

        for (int i = 0; i < 7; i++) begin
            run_instr(tbl[i].word, 1'b0, lat, nwr, wnum);
            check_int($sformatf("latency_%h", tbl[i].word), lat, tbl[i].lat);
            check_int($sformatf("writes_%h", tbl[i].word), nwr, tbl[i].nwr);
            if (tbl[i].nwr > 0)
                check_int($sformatf("writenum_%h", tbl[i].word), int'(wnum), int'(tbl[i].wnum));
        end

        // Load pulsed mid-instruction is ignored, then reset aborts in GET_B.
        build_expect(16'hA16A);
        @(negedge clk);
        in = 16'hA16A; load = 1'b1; s = 1'b1;
        @(negedge clk);
        s = 1'b0; load = 1'b0;
        @(negedge clk);
        check_obs("abort_get_a", sample_dut(), exp_q[1]);
        in = 16'hD2FF; load = 1'b1; s = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        check_obs("abort_get_b_ir_kept", sample_dut(), exp_q[2]);
        #2 reset = 1'b1;
        #1 check_obs("abort_reset_immediate", sample_dut(), rst_obs);
        @(negedge clk);
        check_obs("abort_reset_held", sample_dut(), rst_obs);
        reset = 1'b0;
        @(negedge clk);
        check_obs("abort_wait_after_reset", sample_dut(), rst_obs);
        run_instr(16'hD2FF, 1'b0, lat, nwr, wnum);
        check_int("post_reset_movi_latency", lat, 3);

        // Randomized instructions with noise on s/load/in while busy.
        for (int n = 0; n < 150; n++) begin
            wd = rand_word();
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                in = 16'($urandom); load = 1'b1; s = 1'b0;
                o = blank(in); o.w = 1'b1;
                @(negedge clk);
                load = 1'b0;
                check_obs("load_only_wait", sample_dut(), o);
            end
            run_instr(wd, 1'b1, lat, nwr, wnum);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
